// File: rtl/ot_preproc_pipe_if.sv
// Beat-level handshake bundle between the input buffer, the OT preprocessor and the AES cores.
// Purely wires: no latency of its own.
// Backpressure is carried by out_ready (downstream) and in_ready (upstream).
interface ot_preproc_pipe_if #(
   parameter int LANES = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [1:0]             in_mode;
   logic [LANES*128-1:0]   data_in;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES*128-1:0]   left_out;
   logic [LANES*128-1:0]   right_out;
   logic [1:0]             out_mode;

   // Producer/consumer view (testbench or surrounding fabric)
   modport master (
      output in_valid, in_mode, data_in, out_ready,
      input  in_ready, out_valid, left_out, right_out, out_mode
   );

   // Preprocessor view
   modport slave (
      input  in_valid, in_mode, data_in, out_ready,
      output in_ready, out_valid, left_out, right_out, out_mode
   );
endinterface

// File: rtl/ot_preproc_pipe.sv
// OT input preprocessor: formats LANES x 128-bit blocks into AES left/right operand pairs.
// Latency 1 cycle from accept to out_valid; full 1 beat/cycle throughput.
// Backpressure: in_ready = !out_valid | out_ready; outputs held stable while stalled.
module ot_preproc_pipe #(
   parameter int          LANES    = 8,
   parameter logic [63:0] NONCE    = 64'h777BD5E1B71BFDFE,
   parameter logic [63:0] CTR_INIT = 64'h0,
   parameter bit          MASK_LSB = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ot_preproc_pipe_if.slave     bus,
   input  logic                 delta_load,
   input  logic [127:0]         delta_in,
   input  logic                 ctr_load,
   input  logic [63:0]          ctr_in,
   output logic [63:0]          ctr_value,
   output logic                 err_mode
);

   localparam logic [1:0] M_PRNG = 2'd0;
   localparam logic [1:0] M_CAL  = 2'd1;
   localparam logic [1:0] M_HASH = 2'd2;
   localparam logic [1:0] M_RESV = 2'd3;

   // Bit 0 of x and delta is cleared so the hash pair keeps the point-and-permute bit free
   localparam logic [127:0] HASH_MASK = MASK_LSB ? {{127{1'b1}}, 1'b0} : {128{1'b1}};

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t               state_q, state_d;
   logic                 accept, consume, resv_acc, load_out;
   logic [LANES*128-1:0] left_d, right_d, left_q, right_q;
   logic [1:0]           mode_q;
   logic [63:0]          ctr_q;
   logic [127:0]         delta_q;
   logic                 err_q;

   assign bus.in_ready  = (state_q == EMPTY) | bus.out_ready;
   assign accept        = bus.in_valid & bus.in_ready;
   assign consume       = (state_q == FULL) & bus.out_ready;
   assign resv_acc      = accept & (bus.in_mode == M_RESV);

   assign bus.out_valid = (state_q == FULL);
   assign bus.left_out  = left_q;
   assign bus.right_out = right_q;
   assign bus.out_mode  = mode_q;
   assign ctr_value     = ctr_q;
   assign err_mode      = err_q;

   // Per-lane operand formatting of the incoming beat, using the pre-beat counter and delta
   always_comb begin
      left_d  = '0;
      right_d = '0;
      for (int i = 0; i < LANES; i++) begin
         case (bus.in_mode)
            M_PRNG: begin
               left_d[i*128 +: 128]  = {NONCE, ctr_q + 64'(i)};
               right_d[i*128 +: 128] = bus.data_in[i*128 +: 128];
            end
            M_CAL: begin
               left_d[i*128 +: 128]  = bus.data_in[i*128 +: 128];
               right_d[i*128 +: 128] = bus.data_in[i*128 +: 128];
            end
            M_HASH: begin
               left_d[i*128 +: 128]  = bus.data_in[i*128 +: 128] & HASH_MASK;
               right_d[i*128 +: 128] = (bus.data_in[i*128 +: 128] & HASH_MASK)
                                       ^ (delta_q & HASH_MASK);
            end
            default: begin
               left_d[i*128 +: 128]  = '0;
               right_d[i*128 +: 128] = '0;
            end
         endcase
      end
   end

   // Output-register occupancy: reserved beats are swallowed and never fill the register
   always_comb begin
      state_d  = state_q;
      load_out = 1'b0;
      case (state_q)
         EMPTY: begin
            if (accept && !resv_acc) begin
               state_d  = FULL;
               load_out = 1'b1;
            end
         end
         FULL: begin
            if (accept && !resv_acc) begin
               state_d  = FULL;
               load_out = 1'b1;
            end else if (consume) begin
               state_d  = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Occupancy state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Output beat register, only written on a formatted accept so stalls keep it frozen
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         left_q  <= '0;
         right_q <= '0;
         mode_q  <= 2'd0;
      end else if (load_out) begin
         left_q  <= left_d;
         right_q <= right_d;
         mode_q  <= bus.in_mode;
      end
   end

   // Running PRNG counter; an explicit load overrides the per-beat advance
   always_ff @(posedge clk) begin
      if (!rst_n)                                ctr_q <= CTR_INIT;
      else if (ctr_load)                         ctr_q <= ctr_in;
      else if (accept && bus.in_mode == M_PRNG)  ctr_q <= ctr_q + 64'(LANES);
   end

   // Correlation delta and sticky reserved-mode flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         delta_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (delta_load) delta_q <= delta_in;
         if (resv_acc)   err_q   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ot_preproc_pipe.sv
// Randomized scoreboard bench for ot_preproc_pipe plus a small unmasked-hash instance.
// Driver updates a reference model at each edge; monitor compares every valid output cycle.
// Backpressure is exercised by randomizing out_ready.
module tb_ot_preproc_pipe;
   localparam int          LANES    = 8;
   localparam logic [63:0] NONCE    = 64'h777BD5E1B71BFDFE;
   localparam logic [63:0] CTR_INIT = 64'h0;

   typedef struct {
      logic [1:0]           mode;
      logic [LANES*128-1:0] l;
      logic [LANES*128-1:0] r;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic delta_load, ctr_load;
   logic [127:0] delta_in;
   logic [63:0]  ctr_in, ctr_value;
   logic err_mode;

   logic d2_load;
   logic [127:0] d2_delta;
   logic [63:0]  ctr2_value;
   logic err2;

   int tests = 0;
   int fails = 0;

   exp_t q[$];
   logic         exp_full;
   logic [63:0]  ref_ctr;
   logic [127:0] ref_delta;
   logic         ref_err;

   ot_preproc_pipe_if #(.LANES(LANES)) bus ();
   ot_preproc_pipe_if #(.LANES(1))     bus2 ();

   ot_preproc_pipe #(.LANES(LANES), .NONCE(NONCE), .CTR_INIT(CTR_INIT), .MASK_LSB(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .delta_load(delta_load), .delta_in(delta_in),
      .ctr_load(ctr_load), .ctr_in(ctr_in),
      .ctr_value(ctr_value), .err_mode(err_mode)
   );

   ot_preproc_pipe #(.LANES(1), .NONCE(NONCE), .CTR_INIT(CTR_INIT), .MASK_LSB(1'b0)) dut_nm (
      .clk(clk), .rst_n(rst_n), .bus(bus2),
      .delta_load(d2_load), .delta_in(d2_delta),
      .ctr_load(1'b0), .ctr_in(64'h0),
      .ctr_value(ctr2_value), .err_mode(err2)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Spec-level formatting of one beat into the expected operand pair
   function automatic exp_t model_beat(input logic [1:0] mode, input logic [LANES*128-1:0] d,
                                       input logic [63:0] c, input logic [127:0] dl);
      exp_t e;
      logic [127:0] m, x;
      m = ~128'h1;
      e.mode = mode;
      e.l = '0;
      e.r = '0;
      for (int i = 0; i < LANES; i++) begin
         x = d[i*128 +: 128];
         if (mode == 2'd0) begin
            e.l[i*128 +: 128] = {NONCE, c + 64'(i)};
            e.r[i*128 +: 128] = x;
         end else if (mode == 2'd1) begin
            e.l[i*128 +: 128] = x;
            e.r[i*128 +: 128] = x;
         end else begin
            e.l[i*128 +: 128] = x & m;
            e.r[i*128 +: 128] = (x & m) ^ (dl & m);
         end
      end
      return e;
   endfunction

   // One clock: check handshake/state at negedge, advance the model at posedge
   task automatic tick();
      logic acc;
      @(negedge clk);
      if (rst_n) begin
         chk("in_ready",  {127'h0, bus.in_ready}, {127'h0, (!exp_full || bus.out_ready)});
         chk("out_valid", {127'h0, bus.out_valid}, {127'h0, exp_full});
         chk("ctr_value", {64'h0, ctr_value}, {64'h0, ref_ctr});
         chk("err_mode",  {127'h0, err_mode}, {127'h0, ref_err});
      end
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
         exp_full  = 1'b0;
         ref_ctr   = CTR_INIT;
         ref_delta = '0;
         ref_err   = 1'b0;
      end else begin
         acc = bus.in_valid && (!exp_full || bus.out_ready);
         if (acc && bus.in_mode != 2'd3)
            q.push_back(model_beat(bus.in_mode, bus.data_in, ref_ctr, ref_delta));
         if (acc && bus.in_mode == 2'd3) ref_err = 1'b1;
         exp_full = (acc && bus.in_mode != 2'd3) || (exp_full && !bus.out_ready);
         if (ctr_load) ref_ctr = ctr_in;
         else if (acc && bus.in_mode == 2'd0) ref_ctr = ref_ctr + 64'(LANES);
         if (delta_load) ref_delta = delta_in;
      end
      #1;
   endtask

   function automatic logic [LANES*128-1:0] rnd_data();
      logic [LANES*128-1:0] d;
      for (int k = 0; k < LANES*4; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic beat(input logic [1:0] mode);
      bus.in_valid = 1'b1;
      bus.in_mode  = mode;
      bus.data_in  = rnd_data();
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Monitor: every valid output cycle must match the head of the scoreboard; pop on consume
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         if (q.size() == 0) begin
            chk("unexpected out_valid", 128'h1, 128'h0);
         end else begin
            chk("out_mode", {126'h0, bus.out_mode}, {126'h0, q[0].mode});
            for (int i = 0; i < LANES; i++) begin
               chk($sformatf("left lane %0d", i),  bus.left_out[i*128 +: 128],  q[0].l[i*128 +: 128]);
               chk($sformatf("right lane %0d", i), bus.right_out[i*128 +: 128], q[0].r[i*128 +: 128]);
            end
            if (bus.out_ready) void'(q.pop_front());
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.in_mode = 2'd0; bus.data_in = '0; bus.out_ready = 1'b1;
      bus2.in_valid = 1'b0; bus2.in_mode = 2'd0; bus2.data_in = '0; bus2.out_ready = 1'b1;
      delta_load = 1'b0; delta_in = '0; ctr_load = 1'b0; ctr_in = '0;
      d2_load = 1'b0; d2_delta = '0;
      exp_full = 1'b0; ref_ctr = CTR_INIT; ref_delta = '0; ref_err = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      // Reset state of the output register
      chk("reset left_out lane 0",  bus.left_out[127:0], 128'h0);
      chk("reset right_out lane 0", bus.right_out[127:0], 128'h0);
      chk("reset out_mode", {126'h0, bus.out_mode}, 128'h0);

      // Two PRNG beats, then a masked HASH with delta 5 and lane 0 = F
      beat(2'd0);
      beat(2'd0);
      tick();
      delta_load = 1'b1; delta_in = 128'h5; tick(); delta_load = 1'b0;
      bus.in_valid = 1'b1; bus.in_mode = 2'd2; bus.data_in = rnd_data();
      bus.data_in[127:0] = 128'hF;
      tick();
      bus.in_valid = 1'b0;
      tick();

      // Backpressure for 3 cycles with in_valid held, then 4 back-to-back beats
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_mode = 2'd1; bus.data_in = rnd_data();
      tick();
      for (int k = 0; k < 3; k++) tick();
      bus.out_ready = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) beat(2'(k % 3));
      tick(); tick();

      // Counter wrap and load-wins-over-increment
      ctr_load = 1'b1; ctr_in = 64'hFFFF_FFFF_FFFF_FFFE; tick(); ctr_load = 1'b0;
      beat(2'd0);
      ctr_load = 1'b1; ctr_in = 64'd100; beat(2'd0); ctr_load = 1'b0;
      tick();

      // Reserved mode, then delta load coinciding with a HASH accept
      beat(2'd3);
      tick(); tick();
      delta_load = 1'b1; delta_in = {$urandom, $urandom, $urandom, $urandom};
      beat(2'd2);
      delta_load = 1'b0;
      beat(2'd2);
      tick();

      // Randomized traffic with random backpressure and loads
      for (int n = 0; n < 300; n++) begin
         bus.in_valid  = ($urandom % 4) != 0;
         bus.in_mode   = (($urandom % 30) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         bus.data_in   = rnd_data();
         bus.out_ready = ($urandom % 3) != 0;
         ctr_load      = ($urandom % 20) == 0;
         ctr_in        = (($urandom % 2) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom % 16)
                                               : {$urandom, $urandom};
         delta_load    = ($urandom % 10) == 0;
         delta_in      = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      bus.in_valid = 1'b0; ctr_load = 1'b0; delta_load = 1'b0; bus.out_ready = 1'b1;
      tick(); tick();

      // Reset while a stalled beat sits in the output register
      bus.out_ready = 1'b0;
      beat(2'd0);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      bus.out_ready = 1'b1;
      tick();
      chk("scoreboard drained", 128'(q.size()), 128'h0);

      // Unmasked HASH on the single-lane instance: F with delta 5 -> F / A
      d2_load = 1'b1; d2_delta = 128'h5;
      @(posedge clk); #1;
      d2_load = 1'b0;
      bus2.in_valid = 1'b1; bus2.in_mode = 2'd2; bus2.data_in = 128'hF;
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
      @(negedge clk);
      chk("nomask out_valid", {127'h0, bus2.out_valid}, 128'h1);
      chk("nomask left",  bus2.left_out,  128'hF);
      chk("nomask right", bus2.right_out, 128'hA);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ot_preproc_pipe.md
Name: ot_preproc_pipe

Overview:
- Parametrised, registered successor to the combinational OT input preprocessor.
- Formats LANES x 128-bit blocks into left/right operand pairs for the AES datapath:
  - PRNG seed blocks, built from a nonce and an internal running counter.
  - Plain expand pass-through.
  - Correlation-robust hash pairs (LSB-masked x, and x^delta).
- Sits between the input buffer and the AES cores. Single output register with a valid/ready handshake.
- The runtime counter and the loadable delta replace the fixed compile-time counter.

Parameters:
- LANES, 8: number of 128-bit blocks per beat (1..16).
- NONCE, 64'h777BD5E1B71BFDFE: upper 64 bits of every PRNG block.
- CTR_INIT, 64'h0: counter value after reset.
- MASK_LSB, 1: when 1, HASH clears bit 0 of each lane and of delta; when 0, no masking.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_mode  in  2  0=EXP_PRNG, 1=EXP_CAL, 2=HASH, 3=reserved
- data_in  in  LANES*128  input blocks; lane i at [128i+127:128i]
- delta_load  in  1  load delta_in into the delta register
- delta_in  in  128  OT global correlation delta
- ctr_load  in  1  load ctr_in into the PRNG counter
- ctr_in  in  64  new counter value
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the output beat
- left_out  out  LANES*128  left operands
- right_out  out  LANES*128  right operands
- out_mode  out  2  in_mode of the beat currently in the output register
- ctr_value  out  64  current counter
- err_mode  out  1  sticky flag: a reserved mode was accepted

Behaviour:
- Reset: clk-synchronous, rst_n=0. Values after reset:
  - out_valid=0; left_out, right_out, out_mode = 0.
  - ctr=CTR_INIT, delta=0, err_mode=0.
  - in_ready=1 in the first cycle after reset.
  - A beat held in the output register when reset hits is discarded.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - A beat is accepted when in_valid & in_ready.
  - Latency is 1 cycle: an accepted beat appears on the next edge with out_valid=1.
  - The output beat is consumed when out_valid & out_ready.
  - Accept and consume in the same cycle gives full throughput of 1 beat/cycle, with no bubble.
  - While out_valid=1 and out_ready=0, all outputs stay stable.
- Output state machine, per cycle:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept with consume.
  - FULL -> EMPTY on consume without accept.
- Lane formatting for an accepted beat, lane i = 0..LANES-1, ctr = counter value before the beat:
  - EXP_PRNG: left_i = {NONCE, ctr+i} with the 64-bit sum wrapping mod 2^64; right_i = data_in lane i. Counter advances by LANES (mod 2^64).
  - EXP_CAL: left_i = right_i = data_in lane i. Counter unchanged.
  - HASH: m = MASK_LSB ? 128'hFFFF...FFFE : all-ones; left_i = lane_i & m; right_i = left_i ^ (delta & m). Counter unchanged.
  - Reserved mode (3): the beat is accepted and produces no output (out_valid is not set). err_mode is set and stays set until reset.
- Counter and delta loading:
  - ctr_load in the same cycle as an EXP_PRNG accept: that beat uses the old ctr; next ctr = ctr_in, and the load wins over the increment.
  - delta_load in the same cycle as a HASH accept: that beat uses the old delta; delta = delta_in from the next cycle on.
  - Loads are honoured regardless of the handshake.
- Wrap example: ctr = 64'hFFFF_FFFF_FFFF_FFFE with LANES=8 gives lane counters FFFE, FFFF, 0, 1, ..., 5, and next ctr = 6.
- ctr_value shows the registered counter, i.e. the value after any update at the last edge.

Test Plan:
- Reset, then EXP_PRNG beat with LANES=8 and CTR_INIT=0 -> next cycle out_valid=1, left lane 3 = {NONCE, 64'h3}, right = data_in, ctr_value = 8; a second beat gives lane 0 counter = 8.
- HASH with delta=128'h5, data lane 0 = 128'hF -> left lane 0 = 128'hE, right lane 0 = 128'hA; with MASK_LSB=0: left = F, right = A.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, outputs frozen, no beat lost. Then 4 back-to-back beats with out_ready=1 -> 4 outputs in consecutive cycles, in order.
- Counter wrap: ctr_load of 64'hFFFF_FFFF_FFFF_FFFE, then a PRNG beat -> lane 2 counter = 0, ctr_value = 6. Simultaneous ctr_load=100 with a PRNG accept -> beat uses the old ctr, ctr_value = 100.
- in_mode=3 accepted -> no out_valid, err_mode=1 and sticky. Simultaneous delta_load with a HASH accept -> that beat uses the old delta.
- rst_n=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, ctr=CTR_INIT, err_mode=0.
